// File: rtl/load_store_unit_pkg.sv
// Shared core definitions for the memory-access stage: instruction kinds,
// operand/register widths and load/store classification helpers.
package load_store_unit_pkg;

    localparam int OPERAND_WIDTH             = 32;
    localparam int REGISTER_DESCRIPTOR_WIDTH = 5;

    typedef enum logic [3:0] {
        KIND_ALU = 4'd0,
        KIND_LB  = 4'd1,
        KIND_LH  = 4'd2,
        KIND_LW  = 4'd3,
        KIND_LBU = 4'd4,
        KIND_LHU = 4'd5,
        KIND_SB  = 4'd6,
        KIND_SH  = 4'd7,
        KIND_SW  = 4'd8
    } instr_kind_t;

    function automatic logic is_load(input instr_kind_t kind);
        return kind inside {KIND_LB, KIND_LH, KIND_LW, KIND_LBU, KIND_LHU};
    endfunction

    function automatic logic is_store(input instr_kind_t kind);
        return kind inside {KIND_SB, KIND_SH, KIND_SW};
    endfunction

    // Halfword accesses need an even address, word accesses a 4-byte aligned one.
    function automatic logic is_misaligned(input instr_kind_t kind, input logic [1:0] addr_lo);
        case (kind)
            KIND_LH, KIND_LHU, KIND_SH: return addr_lo[0];
            KIND_LW, KIND_SW:           return addr_lo != 2'b00;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Selects the addressed byte/half/word lane of a read word and sign- or
// zero-extends it according to the load kind.
module load_store_unit_load_extend
    import load_store_unit_pkg::*;
(
    input  logic [OPERAND_WIDTH-1:0] read_word,
    input  logic [1:0]               addr_lo,
    input  instr_kind_t              kind,
    output logic [OPERAND_WIDTH-1:0] extended
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (addr_lo)
            2'd0:    w_byte = read_word[7:0];
            2'd1:    w_byte = read_word[15:8];
            2'd2:    w_byte = read_word[23:16];
            default: w_byte = read_word[31:24];
        endcase
    end

    assign w_half = addr_lo[1] ? read_word[31:16] : read_word[15:0];

    always_comb begin
        case (kind)
            KIND_LB:  extended = {{24{w_byte[7]}}, w_byte};
            KIND_LBU: extended = {24'd0, w_byte};
            KIND_LH:  extended = {{16{w_half[15]}}, w_half};
            KIND_LHU: extended = {16'd0, w_half};
            default:  extended = read_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: issues loads/stores to a single-port data memory and
// registers the write-back value behind a valid/stall handshake.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 valid_input,
    input  logic                                 stall_input,
    input  instr_kind_t                          instr_kind,
    input  logic [OPERAND_WIDTH-1:0]             address,
    input  logic [OPERAND_WIDTH-1:0]             store_data,
    input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rd_addr_input,
    input  logic                                 write_register_input,
    output logic [ADDR_WIDTH-1:0]                dmem_addr,
    output logic                                 dmem_write_enable,
    output logic [3:0]                           dmem_byte_enable,
    output logic [31:0]                          dmem_write_data,
    input  logic [31:0]                          dmem_read_data,
    output logic                                 valid_output,
    output logic                                 stall_output,
    output logic [OPERAND_WIDTH-1:0]             result,
    output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rd_addr_output,
    output logic                                 write_register_output,
    output logic                                 misaligned,
    output logic [1:0]                           dbg_state
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LOAD_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD      = 2'd2;

    // Handshake: an instruction is taken when valid_input && !stall_output; a
    // result is consumed in any cycle valid_output && !stall_input.
    logic [1:0]                           r_state;
    logic                                 r_valid;
    logic                                 r_wr;
    logic                                 r_mis;
    logic [OPERAND_WIDTH-1:0]             r_result;
    logic [REGISTER_DESCRIPTOR_WIDTH-1:0] r_rd;
    logic [1:0]                           r_ld_lo;
    instr_kind_t                          r_ld_kind;
    logic [REGISTER_DESCRIPTOR_WIDTH-1:0] r_ld_rd;
    logic                                 r_ld_wr;

    logic                     w_hold;
    logic                     w_accept;
    logic                     w_mis;
    logic                     w_load;
    logic                     w_store;
    logic [3:0]               w_be;
    logic [31:0]              w_wd;
    logic [OPERAND_WIDTH-1:0] w_load_value;

    assign w_hold       = r_valid && stall_input;
    assign stall_output = (r_state == ST_LOAD_WAIT) || w_hold;
    // rst gates the accept so no memory strobe escapes while reset is held.
    assign w_accept     = rst && valid_input && !stall_output;
    assign w_mis        = is_misaligned(instr_kind, address[1:0]);
    assign w_load       = w_accept && is_load(instr_kind) && !w_mis;
    assign w_store      = w_accept && is_store(instr_kind) && !w_mis;

    always_comb begin
        w_be = 4'b0000;
        w_wd = 32'd0;
        if (w_store) begin
            case (instr_kind)
                KIND_SB: begin
                    w_be = 4'b0001 << address[1:0];
                    w_wd = {4{store_data[7:0]}};
                end
                KIND_SH: begin
                    w_be = 4'b0011 << address[1:0];
                    w_wd = {2{store_data[15:0]}};
                end
                default: begin
                    w_be = 4'b1111;
                    w_wd = store_data;
                end
            endcase
        end
    end

    assign dmem_addr         = (w_load || w_store) ? {address[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign dmem_write_enable = w_store;
    assign dmem_byte_enable  = w_be;
    assign dmem_write_data   = w_wd;

    load_store_unit_load_extend u_load_extend (
        .read_word (dmem_read_data),
        .addr_lo   (r_ld_lo),
        .kind      (r_ld_kind),
        .extended  (w_load_value)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_valid   <= 1'b0;
            r_wr      <= 1'b0;
            r_mis     <= 1'b0;
            r_result  <= '0;
            r_rd      <= '0;
            r_ld_lo   <= 2'b00;
            r_ld_kind <= KIND_ALU;
            r_ld_rd   <= '0;
            r_ld_wr   <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD_WAIT: begin
                    r_valid  <= 1'b1;
                    r_result <= w_load_value;
                    r_rd     <= r_ld_rd;
                    r_wr     <= r_ld_wr;
                    r_mis    <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    if (w_hold) begin
                        r_state <= ST_HOLD;
                    end else begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        if (w_load) begin
                            r_state   <= ST_LOAD_WAIT;
                            r_ld_lo   <= address[1:0];
                            r_ld_kind <= instr_kind;
                            r_ld_rd   <= rd_addr_input;
                            r_ld_wr   <= write_register_input;
                        end else if (w_accept) begin
                            // Stores and faulting accesses complete here without writing rd.
                            r_valid  <= 1'b1;
                            r_result <= address;
                            r_rd     <= rd_addr_input;
                            r_wr     <= write_register_input && !is_store(instr_kind) && !w_mis;
                            r_mis    <= w_mis;
                        end
                    end
                end
            endcase
        end
    end

    assign valid_output          = r_valid;
    assign result                = r_result;
    assign rd_addr_output        = r_rd;
    assign write_register_output = r_wr;
    assign misaligned            = r_mis;
    assign dbg_state             = r_state;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage between execution and write_back in the in-order RV32I core.
- Consumes the execution result (effective address or ALU value), store data and destination register; performs byte/half/word loads and stores on a single-port data memory.
- Presents the final write-back value with the same valid/stall handshake used by the other stages.
- Non-memory instructions pass through with one register stage.

Parameters:
ADDR_WIDTH, 32, data-memory byte-address width; the low 2 bits select the byte lane.
OPERAND_WIDTH, 32, operand and result width; fixed at 32 for RV32I.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-low
- valid_input  input  1  execution presents an instruction this cycle
- stall_input  input  1  write_back cannot accept; hold outputs
- instr_kind  input  instr_kind_t  decoded instruction kind
- address  input  OPERAND_WIDTH  execution result: rs1+imm for load/store, ALU value otherwise
- store_data  input  OPERAND_WIDTH  rs2 value for stores
- rd_addr_input  input  REGISTER_DESCRIPTOR_WIDTH  destination register
- write_register_input  input  1  instruction writes rd
- dmem_addr  output  ADDR_WIDTH  word-aligned address ({address[31:2],2'b00})
- dmem_write_enable  output  1  store strobe
- dmem_byte_enable  output  4  byte-lane mask
- dmem_write_data  output  32  lane-replicated store data
- dmem_read_data  input  32  read data, valid one cycle after the request
- valid_output  output  1  result valid toward write_back
- stall_output  output  1  unit busy; upstream must hold
- result  output  OPERAND_WIDTH  write-back value
- rd_addr_output  output  REGISTER_DESCRIPTOR_WIDTH  registered rd
- write_register_output  output  1  write_back must write rd
- misaligned  output  1  access fault flag, registered with valid_output

Behaviour:
- Reset: state IDLE; every output 0, including dmem_* (no write strobe).
- Reset asserted mid-load abandons the access; no valid_output follows.
- Accept rule: the instruction is taken when valid_input && !stall_output.
- stall_output = (state==LOAD_WAIT) || (valid_output && stall_input).
- FSM states:
  - IDLE: accepting.
  - LOAD_WAIT: one cycle, waiting for read data.
  - HOLD: output is valid but blocked by stall_input.
- Non-memory instruction:
  - Registered next cycle: result=address, write_register_output=write_register_input, valid_output=1.
  - Latency 1.
- Store (SB/SH/SW):
  - In the accept cycle: dmem_write_enable=1 (combinational, gated by accept); byte enables per lane below.
  - Next cycle: valid_output=1, write_register_output=0. Latency 1.
- Load (LB/LH/LW/LBU/LHU):
  - Read issued in the accept cycle; go to LOAD_WAIT.
  - In LOAD_WAIT, select the lane from dmem_read_data, extend it, and register it.
  - valid_output=1 two cycles after accept.
- Byte enables and store data:
  - SB: 4'b0001<<addr[1:0]; data = {4{sd[7:0]}}.
  - SH: 4'b0011<<addr[1:0]; data = {2{sd[15:0]}}.
  - SW: 4'b1111; data = sd.
- Load extract:
  - LB/LBU: byte = data>>(8*addr[1:0]), then sign- or zero-extend.
  - LH/LHU: half at addr[1].
  - LW: whole word.
- Misalignment (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0):
  - No memory access (write_enable=0); latency 1.
  - Output: misaligned=1, write_register_output=0, result=address.
- valid_output is a one-cycle pulse unless stall_input=1.
- HOLD:
  - While stall_input=1, all outputs keep their values.
  - Leave HOLD in the cycle stall_input falls; a new instruction may be accepted that same cycle.
- Back-to-back non-load instructions sustain one per cycle. A load blocks acceptance for exactly one extra cycle.
- Writes to x0 are passed through unchanged; global_register ignores them.

Decomposition:
- Shared core package holds:
  - instr_kind_t, including the load/store kinds;
  - OPERAND_WIDTH and REGISTER_DESCRIPTOR_WIDTH;
  - a localparam function is_load/is_store.
- One natural sub-module: load_extend, purely combinational (read word, addr[1:0], instr_kind → extended result).
- The FSM and store-lane logic stay in load_store_unit.

Test Plan:
- SW store_data=0xDEADBEEF at addr 0x100 → byte_enable=1111, write_data=0xDEADBEEF. Then LW 0x100 → result=0xDEADBEEF two cycles after accept, write_register_output=1.
- Memory word 0x00008000 at 0x104: LB 0x105 → 0xFFFFFF80; LBU 0x105 → 0x00000080; LHU 0x104 → 0x00008000; LH 0x104 → 0xFFFF8000.
- SB store_data=0x000000AB at 0x10A → byte_enable=0100, write_data=0xABABABAB, valid_output next cycle with write_register_output=0.
- LW at 0x102 → no dmem access, misaligned=1, write_register_output=0, latency 1.
- Load completing while stall_input=1 for 3 cycles → result/valid_output stable for 3 cycles, stall_output=1, next instruction accepted in the cycle stall_input drops.
- rst low in LOAD_WAIT → all outputs 0 next edge, no valid_output after rst released. Then ADD result 0x5 → valid_output with result=5 one cycle after accept.
